// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam logic [31:0] LED_ADDR_DEFAULT = 32'h0000_1000;

    function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] strb;
        strb = 4'b0000;
        case (size)
            SZ_BYTE: strb = 4'b0001 << addr_lo;
            SZ_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] addr_lo, input logic is_unsigned);
        logic [31:0] sh;
        logic [31:0] res;
        sh  = word >> {addr_lo, 3'b000};
        res = word;
        case (size)
            SZ_BYTE: res = is_unsigned ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: res = is_unsigned ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised RAM with byte write strobes and a registered read port.
module dmem_ram #(
    parameter int unsigned DEPTH_WORDS = 256,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we_strb_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_strb_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: one request at a time, RAM plus memory-mapped LED register.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] LED_ADDR    = LED_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        led
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 4;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [1:0]         size_q;
    logic               unsigned_q;
    logic               req_ready_q;
    logic               resp_valid_q;
    logic [31:0]        resp_rdata_q;
    logic               resp_err_q;
    logic               led_q;

    logic               in_ram_c;
    logic               is_led_c;
    logic               err_c;
    logic               commit_c;
    logic [3:0]         ram_strb_c;
    logic [31:0]        ram_wdata_c;
    logic [AW-1:0]      ram_raddr_c;
    logic [31:0]        ram_rdata;
    logic [31:0]        load_data_c;

    // Decode of the latched request; only meaningful outside IDLE.
    always_comb begin
        in_ram_c = (addr_q[31:AW+2] == '0);
        is_led_c = (addr_q == LED_ADDR);
        err_c    = 1'b0;
        if (size_q == 2'd3) begin
            err_c = 1'b1;
        end else if (size_q == SZ_HALF && addr_q[0]) begin
            err_c = 1'b1;
        end else if (size_q == SZ_WORD && addr_q[1:0] != 2'b00) begin
            err_c = 1'b1;
        end else if (is_led_c && size_q != SZ_WORD) begin
            err_c = 1'b1;
        end else if (!in_ram_c && !is_led_c) begin
            err_c = 1'b1;
        end
    end

    assign commit_c    = (state_q == ST_WAIT) && (cnt_q == '0);
    assign ram_strb_c  = (commit_c && we_q && !err_c && in_ram_c) ? store_strobe(size_q, addr_q[1:0]) : 4'b0000;
    assign ram_wdata_c = (size_q == SZ_BYTE) ? {4{wdata_q[7:0]}} :
                         (size_q == SZ_HALF) ? {2{wdata_q[15:0]}} : wdata_q;
    // Read is issued from the live request on the accept edge so data is ready by commit.
    assign ram_raddr_c = (state_q == ST_IDLE) ? req_addr[AW+1:2] : addr_q[AW+1:2];
    assign load_data_c = is_led_c ? {31'b0, led_q} : load_extend(ram_rdata, size_q, addr_q[1:0], unsigned_q);

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk       (clk),
        .we_strb_i (ram_strb_c),
        .waddr_i   (addr_q[AW+1:2]),
        .wdata_i   (ram_wdata_c),
        .raddr_i   (ram_raddr_c),
        .rdata_o   (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            unsigned_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            led_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        we_q        <= req_we;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        size_q      <= req_size;
                        unsigned_q  <= req_unsigned;
                        cnt_q       <= CNT_W'(WAIT_STATES);
                        req_ready_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= err_c;
                        resp_rdata_q <= (err_c || we_q) ? 32'h0 : load_data_c;
                        if (!err_c && we_q && is_led_c) begin
                            led_q <= wdata_q[0];
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign led        = led_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: two instances (1 and 3 wait states) share request inputs.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst1_n, rst3_n;
    logic        req_valid, req_we, req_unsigned, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;

    logic        req_ready1, resp_valid1, resp_err1, led1;
    logic [31:0] resp_rdata1;
    logic        req_ready3, resp_valid3, resp_err3, led3;
    logic [31:0] resp_rdata3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1), .LED_ADDR(32'h0000_1000)) u_dut1 (
        .clk(clk), .reset(rst1_n), .req_valid(req_valid), .req_ready(req_ready1),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .resp_valid(resp_valid1), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1), .led(led1)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3), .LED_ADDR(32'h0000_1000)) u_dut3 (
        .clk(clk), .reset(rst3_n), .req_valid(req_valid), .req_ready(req_ready3),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .resp_valid(resp_valid3), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata3), .resp_err(resp_err3), .led(led3)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_led;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic rv_f(input bit d3);
        return d3 ? resp_valid3 : resp_valid1;
    endfunction

    // One full transaction; lat is the number of edges after the accept edge until resp_valid.
    task automatic txn(input bit d3, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       output logic [31:0] rdata, output logic err, output logic ld, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rv_f(d3) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        lat   = n;
        rdata = d3 ? resp_rdata3 : resp_rdata1;
        err   = d3 ? resp_err3 : resp_err1;
        ld    = d3 ? led3 : led1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er, ld;
        int          lat, n;

        vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 2'd2, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'h10,   32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 32'h13,   32'h00000080, 2'd0, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'h13,   32'h0,        2'd0, 1'b0, 32'hFFFFFF80, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'h13,   32'h0,        2'd0, 1'b1, 32'h00000080, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'h10,   32'h0,        2'd2, 1'b0, 32'h80ADBEEF, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'h11,   32'h0,        2'd1, 1'b0, 32'h0,        1'b1, 1'b0};
        vecs[7]  = '{1'b0, 32'h12,   32'h0,        2'd2, 1'b0, 32'h0,        1'b1, 1'b0};
        vecs[8]  = '{1'b0, 32'h800,  32'h0,        2'd2, 1'b0, 32'h0,        1'b1, 1'b0};
        vecs[9]  = '{1'b0, 32'h10,   32'h0,        2'd2, 1'b1, 32'h80ADBEEF, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 32'h12,   32'h0,        2'd1, 1'b0, 32'hFFFF80AD, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 32'h12,   32'h0,        2'd1, 1'b1, 32'h000080AD, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 32'h14,   32'h11223344, 2'd2, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[13] = '{1'b1, 32'h16,   32'h0000BEEF, 2'd1, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[14] = '{1'b1, 32'h15,   32'h0000AA55, 2'd0, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[15] = '{1'b0, 32'h14,   32'h0,        2'd2, 1'b0, 32'hBEEF5544, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 32'h15,   32'h0,        2'd0, 1'b0, 32'h00000055, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 32'h16,   32'h0,        2'd1, 1'b0, 32'hFFFFBEEF, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 32'h15,   32'h0,        2'd2, 1'b0, 32'h0,        1'b1, 1'b0};
        vecs[19] = '{1'b0, 32'h14,   32'h0,        2'd2, 1'b0, 32'hBEEF5544, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 32'h1000, 32'h00000001, 2'd2, 1'b0, 32'h0,        1'b0, 1'b1};
        vecs[21] = '{1'b0, 32'h1000, 32'h0,        2'd2, 1'b0, 32'h00000001, 1'b0, 1'b1};
        vecs[22] = '{1'b1, 32'h1000, 32'h0,        2'd0, 1'b0, 32'h0,        1'b1, 1'b1};
        vecs[23] = '{1'b0, 32'h10,   32'h0,        2'd3, 1'b0, 32'h0,        1'b1, 1'b1};
        vecs[24] = '{1'b0, 32'h1000, 32'h0,        2'd2, 1'b0, 32'h00000001, 1'b0, 1'b1};

        rst1_n = 1'b0; rst3_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready",  32'(req_ready1),  32'h1);
        chk("rst_resp_valid", 32'(resp_valid1), 32'h0);
        chk("rst_rdata",      resp_rdata1,      32'h0);
        chk("rst_err",        32'(resp_err1),   32'h0);
        chk("rst_led",        32'(led1),        32'h0);
        chk("rst3_req_ready", 32'(req_ready3),  32'h1);
        @(negedge clk);
        rst1_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            txn(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, rd, er, ld, lat);
            chk($sformatf("v%0d_rdata", i), rd,        vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i),   32'(er),   32'(vecs[i].exp_err));
            chk($sformatf("v%0d_led", i),   32'(ld),   32'(vecs[i].exp_led));
            chk($sformatf("v%0d_lat", i),   32'(lat),  32'd2);
        end

        // Response held off: outputs stable, new requests ignored.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_unsigned = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold_lat", 32'(n), 32'd2);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_size = 2'd2;
            @(posedge clk); #1;
            chk($sformatf("hold%0d_valid", i), 32'(resp_valid1), 32'h1);
            chk($sformatf("hold%0d_rdata", i), resp_rdata1,      32'h80ADBEEF);
            chk($sformatf("hold%0d_err", i),   32'(resp_err1),   32'h0);
            chk($sformatf("hold%0d_ready", i), 32'(req_ready1),  32'h0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("rel_valid", 32'(resp_valid1), 32'h0);
        chk("rel_ready", 32'(req_ready1),  32'h1);
        txn(1'b0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd, er, ld, lat);
        chk("after_hold_rdata", rd,        32'h80ADBEEF);
        chk("after_hold_lat",   32'(lat),  32'd2);

        // Reset during WAIT on the 3-wait-state instance.
        rst1_n = 1'b0;
        @(negedge clk);
        rst3_n = 1'b1;
        txn(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 2'd2, 1'b0, rd, er, ld, lat);
        chk("w3_store_err", 32'(er),  32'h0);
        chk("w3_store_lat", 32'(lat), 32'd4);
        txn(1'b1, 1'b1, 32'h1000, 32'h1, 2'd2, 1'b0, rd, er, ld, lat);
        chk("w3_led_set", 32'(ld), 32'h1);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_size = 2'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst3_n = 1'b0;
        #1;
        chk("abort_valid", 32'(resp_valid3), 32'h0);
        chk("abort_led",   32'(led3),        32'h0);
        chk("abort_ready", 32'(req_ready3),  32'h1);
        @(negedge clk);
        rst3_n = 1'b1;
        txn(1'b1, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, rd, er, ld, lat);
        chk("abort_rdata", rd,       32'hA5A5A5A5);
        chk("abort_err",   32'(er),  32'h0);
        chk("abort_lat",   32'(lat), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
